dispatch_unit: RTL and testbench

Dispatch stage between the rename stage and the ALU, branch and LSU reservation stations. It buffers renamed instructions in a 2-entry skid buffer and routes each one to the reservation station for its functional-unit class. It allocates a ROB entry in the same cycle and drives per-operand ready bits from an internal physical-register busy table, which writeback broadcasts clear. It generates the reservation-station allocation pulse and never asserts it while the target station is full.

---
 rtl/dispatch_unit_pkg.sv | 18 +
 rtl/dispatch_unit_busy_table.sv | 42 ++++
 rtl/dispatch_unit.sv | 118 +++++++++++
 tb/tb_dispatch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_unit_pkg.sv
// dispatch_unit_pkg: shared functional-unit encodings and the dispatch payload record
package dispatch_unit_pkg;
    localparam int PREG_W = 7;
    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_BR  = 2'd1;
    localparam logic [1:0] FU_LSU = 2'd2;
    localparam logic [1:0] FU_ILL = 2'd3;
    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic [PREG_W-1:0] prd;
        logic              has_rd;
        logic [3:0]        alu_op;
        logic [1:0]        fu_type;
    } dispatch_payload_t;
endpackage

// File: rtl/dispatch_unit_busy_table.sv
// busy_table: per-physical-register pending bits with writeback bypass on two read ports
module busy_table #(
    parameter int PREG_WIDTH = 7,
    parameter int NUM_WB     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         set_en,
    input  logic [PREG_WIDTH-1:0]        set_idx,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*PREG_WIDTH-1:0] wb_prd,
    input  logic [PREG_WIDTH-1:0]        rd_a,
    input  logic [PREG_WIDTH-1:0]        rd_b,
    output logic                         ready_a,
    output logic                         ready_b
);
    localparam int N = 1 << PREG_WIDTH;
    logic [N-1:0] busy, busy_n;
    logic byp_a, byp_b;
    // clears from every writeback port first so a same-cycle allocation set wins; p0 never busy
    always_comb begin
        busy_n = busy;
        for (int k = 0; k < NUM_WB; k++)
            if (wb_valid[k]) busy_n[wb_prd[k*PREG_WIDTH +: PREG_WIDTH]] = 1'b0;
        if (set_en) busy_n[set_idx] = 1'b1;
        busy_n[0] = 1'b0;
    end
    // writeback broadcasts in the current cycle make an operand ready without waiting for the table
    always_comb begin
        byp_a = 1'b0;
        byp_b = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            byp_a = byp_a | (wb_valid[k] && wb_prd[k*PREG_WIDTH +: PREG_WIDTH] == rd_a);
            byp_b = byp_b | (wb_valid[k] && wb_prd[k*PREG_WIDTH +: PREG_WIDTH] == rd_b);
        end
    end
    assign ready_a = (rd_a == '0) || !busy[rd_a] || byp_a;
    assign ready_b = (rd_b == '0) || !busy[rd_b] || byp_b;
    // table register
    always_ff @(posedge clk)
        busy <= reset ? '0 : busy_n;
endmodule

// File: rtl/dispatch_unit.sv
// dispatch_unit: two-entry skid buffer routing renamed instructions to ROB and reservation stations
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int PREG_WIDTH = PREG_W,
    parameter int ROB_WIDTH  = 4,
    parameter int NUM_WB     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [31:0]                  i_pc,
    input  logic [31:0]                  i_imm,
    input  logic [PREG_WIDTH-1:0]        i_prs1,
    input  logic [PREG_WIDTH-1:0]        i_prs2,
    input  logic [PREG_WIDTH-1:0]        i_prd,
    input  logic                         i_has_rd,
    input  logic [3:0]                   i_alu_op,
    input  logic [1:0]                   i_fu_type,
    input  logic                         i_alu_full,
    input  logic                         i_br_full,
    input  logic                         i_lsu_full,
    input  logic                         i_rob_full,
    input  logic [ROB_WIDTH-1:0]         i_rob_tag,
    output logic                         o_rob_alloc,
    output logic                         o_rob_exc,
    output logic                         o_alu_alloc,
    output logic                         o_br_alloc,
    output logic                         o_lsu_alloc,
    output logic [31:0]                  o_pc,
    output logic [31:0]                  o_imm,
    output logic [PREG_WIDTH-1:0]        o_prs1,
    output logic [PREG_WIDTH-1:0]        o_prs2,
    output logic [PREG_WIDTH-1:0]        o_prd,
    output logic [3:0]                   o_alu_op,
    output logic [ROB_WIDTH-1:0]         o_rob_tag,
    output logic                         o_rs1_ready,
    output logic                         o_rs2_ready,
    input  logic [NUM_WB-1:0]            i_wb_valid,
    input  logic [NUM_WB*PREG_WIDTH-1:0] i_wb_prd,
    input  logic                         branch_mispredict
);
    dispatch_payload_t in_p, head, spill, head_n, spill_n;
    logic head_v, spill_v, head_vn, spill_vn, ready_r;
    logic accept, target_full, fire;
    assign in_p = '{pc: i_pc, imm: i_imm, prs1: i_prs1, prs2: i_prs2, prd: i_prd,
                    has_rd: i_has_rd, alu_op: i_alu_op, fu_type: i_fu_type};
    assign o_ready = ready_r && !reset;
    assign accept = i_valid && o_ready;
    assign target_full = head.fu_type == FU_ALU ? i_alu_full :
                         head.fu_type == FU_BR  ? i_br_full  :
                         head.fu_type == FU_LSU ? i_lsu_full : 1'b0;
    assign fire = head_v && !target_full && !i_rob_full && !branch_mispredict;
    assign o_rob_alloc = fire;
    assign o_rob_exc   = fire && head.fu_type == FU_ILL;
    assign o_alu_alloc = fire && head.fu_type == FU_ALU;
    assign o_br_alloc  = fire && head.fu_type == FU_BR;
    assign o_lsu_alloc = fire && head.fu_type == FU_LSU;
    assign o_rob_tag = i_rob_tag;
    assign o_pc      = head.pc;
    assign o_imm     = head.imm;
    assign o_prs1    = head.prs1;
    assign o_prs2    = head.prs2;
    assign o_prd     = head.prd;
    assign o_alu_op  = head.alu_op;
    // skid advance: spill refills the head on fire, otherwise accepted beats fill head then spill
    always_comb begin
        head_vn  = head_v;
        head_n   = head;
        spill_vn = spill_v;
        spill_n  = spill;
        if (branch_mispredict) begin
            head_vn  = 1'b0;
            spill_vn = 1'b0;
        end else if (fire) begin
            head_vn  = spill_v || accept;
            head_n   = spill_v ? spill : in_p;
            spill_vn = 1'b0;
        end else if (accept) begin
            if (!head_v) begin
                head_vn = 1'b1;
                head_n  = in_p;
            end else begin
                spill_vn = 1'b1;
                spill_n  = in_p;
            end
        end
    end
    // buffer state; ready is registered from the next spill state so a full spill never overflows
    always_ff @(posedge clk) begin
        if (reset) begin
            head_v  <= 1'b0;
            spill_v <= 1'b0;
            head    <= '0;
            spill   <= '0;
            ready_r <= 1'b1;
        end else begin
            head_v  <= head_vn;
            spill_v <= spill_vn;
            head    <= head_n;
            spill   <= spill_n;
            ready_r <= !spill_vn;
        end
    end
    busy_table #(.PREG_WIDTH(PREG_WIDTH), .NUM_WB(NUM_WB)) u_busy (
        .clk      (clk),
        .reset    (reset),
        .set_en   (fire && head.has_rd && head.prd != '0),
        .set_idx  (head.prd),
        .wb_valid (i_wb_valid),
        .wb_prd   (i_wb_prd),
        .rd_a     (head.prs1),
        .rd_b     (head.prs2),
        .ready_a  (o_rs1_ready),
        .ready_b  (o_rs2_ready)
    );
endmodule

// File: tb/tb_dispatch_unit.sv
// tb_dispatch_unit: directed cycle-by-cycle checks of dispatch routing, skid buffering and busy tracking
module tb_dispatch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc, i_imm;
    logic [6:0]  i_prs1, i_prs2, i_prd;
    logic        i_has_rd;
    logic [3:0]  i_alu_op;
    logic [1:0]  i_fu_type;
    logic        i_alu_full, i_br_full, i_lsu_full, i_rob_full;
    logic [3:0]  i_rob_tag;
    logic        o_rob_alloc, o_rob_exc, o_alu_alloc, o_br_alloc, o_lsu_alloc;
    logic [31:0] o_pc, o_imm;
    logic [6:0]  o_prs1, o_prs2, o_prd;
    logic [3:0]  o_alu_op, o_rob_tag;
    logic        o_rs1_ready, o_rs2_ready;
    logic [1:0]  i_wb_valid;
    logic [13:0] i_wb_prd;
    logic        branch_mispredict;
    int checks = 0;
    int errors = 0;

    dispatch_unit dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_imm(i_imm), .i_prs1(i_prs1), .i_prs2(i_prs2), .i_prd(i_prd),
        .i_has_rd(i_has_rd), .i_alu_op(i_alu_op), .i_fu_type(i_fu_type),
        .i_alu_full(i_alu_full), .i_br_full(i_br_full), .i_lsu_full(i_lsu_full),
        .i_rob_full(i_rob_full), .i_rob_tag(i_rob_tag),
        .o_rob_alloc(o_rob_alloc), .o_rob_exc(o_rob_exc),
        .o_alu_alloc(o_alu_alloc), .o_br_alloc(o_br_alloc), .o_lsu_alloc(o_lsu_alloc),
        .o_pc(o_pc), .o_imm(o_imm), .o_prs1(o_prs1), .o_prs2(o_prs2), .o_prd(o_prd),
        .o_alu_op(o_alu_op), .o_rob_tag(o_rob_tag),
        .o_rs1_ready(o_rs1_ready), .o_rs2_ready(o_rs2_ready),
        .i_wb_valid(i_wb_valid), .i_wb_prd(i_wb_prd), .branch_mispredict(branch_mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        i_valid    = 1'b0;
        i_wb_valid = '0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] fu, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] d, input logic hr, input logic [31:0] pc);
        i_valid   = 1'b1;
        i_fu_type = fu;
        i_prs1    = s1;
        i_prs2    = s2;
        i_prd     = d;
        i_has_rd  = hr;
        i_pc      = pc;
        i_imm     = pc ^ 32'h0000ffff;
        i_alu_op  = pc[5:2];
    endtask

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_pc = '0; i_imm = '0; i_prs1 = '0; i_prs2 = '0;
        i_prd = '0; i_has_rd = 1'b0; i_alu_op = '0; i_fu_type = '0;
        i_alu_full = 1'b0; i_br_full = 1'b0; i_lsu_full = 1'b0; i_rob_full = 1'b0;
        i_rob_tag = 4'h3; i_wb_valid = '0; i_wb_prd = '0; branch_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_ready", o_ready, 0);
        chk("rst_rob_alloc", o_rob_alloc, 0);
        chk("rst_alu_alloc", o_alu_alloc, 0);
        chk("rst_rs1_ready", o_rs1_ready, 1);
        // producer p9 enters
        nxt(); reset = 1'b0; send(2'd0, 7'd5, 7'd6, 7'd9, 1'b1, 32'h100);
        mid();
        chk("post_rst_ready", o_ready, 1);
        chk("latency_no_alloc", o_alu_alloc, 0);
        // producer fires, consumer of p9 enters
        nxt(); send(2'd0, 7'd9, 7'd0, 7'd3, 1'b0, 32'h104);
        mid();
        chk("prod_alu_alloc", o_alu_alloc, 1);
        chk("prod_rob_alloc", o_rob_alloc, 1);
        chk("prod_br_alloc", o_br_alloc, 0);
        chk("prod_exc", o_rob_exc, 0);
        chk("prod_rs1", o_rs1_ready, 1);
        chk("prod_rs2", o_rs2_ready, 1);
        chk("prod_prd", o_prd, 9);
        chk("prod_pc", o_pc, 32'h100);
        chk("prod_imm", o_imm, 32'h0000feff);
        chk("prod_tag", o_rob_tag, 4'h3);
        // dependent consumer sees p9 busy
        nxt();
        mid();
        chk("dep_alloc", o_alu_alloc, 1);
        chk("dep_pc", o_pc, 32'h104);
        chk("dep_rs1_busy", o_rs1_ready, 0);
        nxt(); send(2'd0, 7'd9, 7'd5, 7'd0, 1'b0, 32'h108);
        mid();
        chk("empty_no_alloc", o_rob_alloc, 0);
        // writeback p9 on port 1 while consumer at head
        nxt(); send(2'd0, 7'd9, 7'd5, 7'd0, 1'b0, 32'h10c);
        i_wb_valid = 2'b10; i_wb_prd = {7'd9, 7'd0};
        mid();
        chk("byp_pc", o_pc, 32'h108);
        chk("byp_rs1", o_rs1_ready, 1);
        chk("byp_rs2", o_rs2_ready, 1);
        nxt();
        mid();
        chk("clr_alloc", o_alu_alloc, 1);
        chk("clr_pc", o_pc, 32'h10c);
        chk("clr_rs1", o_rs1_ready, 1);
        // backpressure: ALU full, three beats
        nxt(); i_alu_full = 1'b1; send(2'd0, 7'd0, 7'd0, 7'd0, 1'b0, 32'h200);
        mid();
        chk("bp_ready0", o_ready, 1);
        nxt(); send(2'd0, 7'd0, 7'd0, 7'd0, 1'b0, 32'h204);
        mid();
        chk("bp_ready1", o_ready, 1);
        chk("bp_blocked", o_alu_alloc, 0);
        chk("bp_blocked_rob", o_rob_alloc, 0);
        nxt(); send(2'd0, 7'd0, 7'd0, 7'd0, 1'b0, 32'h208);
        mid();
        chk("bp_ready_low", o_ready, 0);
        nxt(); send(2'd0, 7'd0, 7'd0, 7'd0, 1'b0, 32'h208); i_alu_full = 1'b0;
        mid();
        chk("drain0_alloc", o_alu_alloc, 1);
        chk("drain0_pc", o_pc, 32'h200);
        chk("drain0_ready", o_ready, 0);
        nxt(); send(2'd0, 7'd0, 7'd0, 7'd0, 1'b0, 32'h208);
        mid();
        chk("drain1_alloc", o_alu_alloc, 1);
        chk("drain1_pc", o_pc, 32'h204);
        chk("drain1_ready", o_ready, 1);
        nxt();
        mid();
        chk("drain2_alloc", o_alu_alloc, 1);
        chk("drain2_pc", o_pc, 32'h208);
        // illegal instruction with every RS full
        nxt(); i_rob_tag = 4'hA; i_alu_full = 1'b1; i_br_full = 1'b1; i_lsu_full = 1'b1;
        send(2'd3, 7'd1, 7'd2, 7'd0, 1'b0, 32'h300);
        mid();
        chk("ill_pre_rob", o_rob_alloc, 0);
        nxt(); send(2'd1, 7'd0, 7'd0, 7'd12, 1'b1, 32'h304);
        mid();
        chk("ill_rob", o_rob_alloc, 1);
        chk("ill_exc", o_rob_exc, 1);
        chk("ill_alu", o_alu_alloc, 0);
        chk("ill_br", o_br_alloc, 0);
        chk("ill_lsu", o_lsu_alloc, 0);
        chk("ill_tag", o_rob_tag, 4'hA);
        chk("ill_pc", o_pc, 32'h300);
        // branch routes, LSU beat queued behind full LSU station
        nxt(); i_br_full = 1'b0; i_rob_tag = 4'h5; send(2'd2, 7'd0, 7'd0, 7'd20, 1'b1, 32'h308);
        mid();
        chk("br_alloc", o_br_alloc, 1);
        chk("br_exc", o_rob_exc, 0);
        chk("br_tag", o_rob_tag, 4'h5);
        chk("br_pc", o_pc, 32'h304);
        nxt(); send(2'd2, 7'd0, 7'd0, 7'd21, 1'b1, 32'h30c);
        mid();
        chk("lsu_blocked", o_lsu_alloc, 0);
        chk("lsu_ready", o_ready, 1);
        // mispredict with head and spill both valid
        nxt(); i_lsu_full = 1'b0; branch_mispredict = 1'b1;
        mid();
        chk("mp_ready", o_ready, 0);
        chk("mp_lsu", o_lsu_alloc, 0);
        chk("mp_rob", o_rob_alloc, 0);
        nxt(); branch_mispredict = 1'b0;
        mid();
        chk("mp_after_ready", o_ready, 1);
        chk("mp_after_lsu", o_lsu_alloc, 0);
        chk("mp_after_rob", o_rob_alloc, 0);
        // p12 from the fired branch stays busy, p20 from the squashed LSU never set
        nxt(); i_alu_full = 1'b0; send(2'd0, 7'd12, 7'd20, 7'd0, 1'b0, 32'h400);
        mid();
        nxt(); send(2'd0, 7'd0, 7'd0, 7'd0, 1'b1, 32'h404);
        mid();
        chk("keep_alloc", o_alu_alloc, 1);
        chk("keep_rs1_busy", o_rs1_ready, 0);
        chk("keep_rs2_ready", o_rs2_ready, 1);
        // p0 destination never marks busy
        nxt(); send(2'd0, 7'd0, 7'd0, 7'd15, 1'b1, 32'h408);
        mid();
        chk("p0_rs1", o_rs1_ready, 1);
        chk("p0_pc", o_pc, 32'h404);
        // set and clear of p15 in the same cycle: set wins
        nxt(); send(2'd0, 7'd15, 7'd0, 7'd0, 1'b0, 32'h40c);
        i_wb_valid = 2'b01; i_wb_prd = {7'd0, 7'd15};
        mid();
        chk("p0_after_rs1", o_rs1_ready, 1);
        chk("p0_after_rs2", o_rs2_ready, 1);
        chk("setwin_prod_pc", o_pc, 32'h408);
        nxt();
        mid();
        chk("setwin_pc", o_pc, 32'h40c);
        chk("setwin_rs1_busy", o_rs1_ready, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
